// File: rtl/vga_pkg.sv
// 640x480@60 timing constants and pixel width shared by the scanline path.
package vga_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_TOTAL   = 800;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_TOTAL   = 525;
  localparam int unsigned HS_START  = 656;
  localparam int unsigned HS_END    = 751;
  localparam int unsigned VS_START  = 490;
  localparam int unsigned VS_END    = 491;
  localparam int unsigned BPP       = 6;

  // Row index 'ahead' lines after row, wrapping at the end of the frame.
  function automatic logic [9:0] wrap_row(input logic [9:0] row, input logic [1:0] ahead);
    logic [10:0] s;
    s = {1'b0, row} + {9'd0, ahead};
    if (s >= 11'(V_TOTAL)) s = s - 11'(V_TOTAL);
    return s[9:0];
  endfunction

endpackage

// File: rtl/scanline_buffer_line_bank.sv
// One scanline of pixel storage: synchronous write, registered read, no reset on contents.
module line_bank #(
  parameter int unsigned DEPTH = 80,
  parameter int unsigned WIDTH = 6,
  parameter int unsigned AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (waddr < AW'(DEPTH))) mem[waddr] <= wdata;
    // Reads past the stored width only happen during blanking; return zero there.
    rdata <= (raddr < AW'(DEPTH)) ? mem[raddr] : '0;
  end

endmodule

// File: rtl/scanline_buffer.sv
// Ping-pong scanline buffer: back bank filled by the renderer, front bank scanned out with
// horizontal pixel replication. line_req/req_line are registered and pulse the cycle after x==799.
module scanline_buffer #(
  parameter int unsigned LINE_PIXELS = 80,
  parameter int unsigned SCALE_LOG2  = 3,
  parameter int unsigned BPP         = vga_pkg::BPP
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [9:0]     x,
  input  logic [9:0]     y,
  input  logic           blank,
  input  logic           hs_in,
  input  logic           vs_in,
  input  logic           wr_en,
  input  logic [6:0]     wr_addr,
  input  logic [BPP-1:0] wr_data,
  input  logic           wr_done,
  output logic           line_req,
  output logic [8:0]     req_line,
  output logic [BPP-1:0] rgb,
  output logic           hs_out,
  output logic           vs_out,
  output logic           underflow
);

  import vga_pkg::*;

  logic       front_sel_q, front_sel_d;
  logic [1:0] valid_q, valid_d;
  logic       underflow_q, underflow_d;
  logic       line_req_q, line_req_d;
  logic [8:0] req_line_q, req_line_d;

  logic       back_sel;
  logic       swap;
  logic       back_ok;
  logic [9:0] show_row;
  logic [9:0] render_row;

  assign back_sel   = ~front_sel_q;
  assign swap       = (x == 10'(H_TOTAL - 1));
  // A wr_done in the swap cycle itself still counts for the bank about to be shown.
  assign back_ok    = valid_q[back_sel] | wr_done;
  assign show_row   = wrap_row(y, 2'd1);
  assign render_row = wrap_row(y, 2'd2);

  always_comb begin
    front_sel_d = front_sel_q;
    valid_d     = valid_q;
    underflow_d = underflow_q;
    line_req_d  = 1'b0;
    req_line_d  = req_line_q;
    if (wr_done) valid_d[back_sel] = 1'b1;
    if (swap) begin
      front_sel_d          = back_sel;
      valid_d[front_sel_q] = 1'b0;
      if ((show_row < 10'(V_VISIBLE)) && !back_ok) underflow_d = 1'b1;
      if (render_row < 10'(V_VISIBLE)) begin
        line_req_d = 1'b1;
        req_line_d = render_row[8:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front_sel_q <= 1'b0;
      valid_q     <= 2'b00;
      underflow_q <= 1'b0;
      line_req_q  <= 1'b0;
      req_line_q  <= 9'd0;
    end else begin
      front_sel_q <= front_sel_d;
      valid_q     <= valid_d;
      underflow_q <= underflow_d;
      line_req_q  <= line_req_d;
      req_line_q  <= req_line_d;
    end
  end

  // Stage 1: column to stored-pixel address, plus the signals that must travel with it.
  logic [6:0] rd_addr_q;
  logic       blank_q, front_valid_q, sel1_q, hs1_q, vs1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_q     <= 7'd0;
      blank_q       <= 1'b0;
      front_valid_q <= 1'b0;
      sel1_q        <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
    end else begin
      rd_addr_q     <= 7'(x >> SCALE_LOG2);
      blank_q       <= blank;
      front_valid_q <= valid_q[front_sel_q];
      sel1_q        <= front_sel_q;
      hs1_q         <= hs_in;
      vs1_q         <= vs_in;
    end
  end

  // Stage 2: bank read data registers inside line_bank alongside the gating flags here.
  logic           show_q, sel2_q, hs2_q, vs2_q;
  logic [BPP-1:0] rdata0, rdata1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      show_q <= 1'b0;
      sel2_q <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
    end else begin
      show_q <= ~blank_q & front_valid_q;
      sel2_q <= sel1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

  line_bank #(
    .DEPTH (LINE_PIXELS),
    .WIDTH (BPP),
    .AW    (7)
  ) u_bank0 (
    .clk   (clk),
    .we    (wr_en & (back_sel == 1'b0)),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr_q),
    .rdata (rdata0)
  );

  line_bank #(
    .DEPTH (LINE_PIXELS),
    .WIDTH (BPP),
    .AW    (7)
  ) u_bank1 (
    .clk   (clk),
    .we    (wr_en & (back_sel == 1'b1)),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr_q),
    .rdata (rdata1)
  );

  assign rgb       = show_q ? (sel2_q ? rdata1 : rdata0) : '0;
  assign hs_out    = hs2_q;
  assign vs_out    = vs2_q;
  assign line_req  = line_req_q;
  assign req_line  = req_line_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_scanline_buffer.sv
// Randomized bench for scanline_buffer against a line-copy reference model.
module tb_scanline_buffer;

  import vga_pkg::*;

  logic       clk, reset;
  logic [9:0] x, y;
  logic       blank, hs_in, vs_in;
  logic       wr_en, wr_done;
  logic [6:0] wr_addr;
  logic [5:0] wr_data;
  logic       line_req, hs_out, vs_out, underflow;
  logic [8:0] req_line;
  logic [5:0] rgb;

  scanline_buffer #(
    .LINE_PIXELS (80),
    .SCALE_LOG2  (3),
    .BPP         (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .blank     (blank),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_done   (wr_done),
    .line_req  (line_req),
    .req_line  (req_line),
    .rgb       (rgb),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (x=%0d y=%0d t=%0t)", tag, got, exp, x, y, $time);
    end
  endtask

  // Reference model: the displayed line and the line being rendered as plain pixel arrays.
  // -1 marks a pixel whose contents are unknown (never written since reset).
  int  front_pix[80];
  int  back_pix[80];
  bit  front_ok, back_ok;
  bit  m_uf, m_req;
  int  m_req_line;

  typedef struct {
    int rgb;
    int hs;
    int vs;
  } exp_t;
  exp_t pipe[$];

  task automatic model_reset();
    for (int i = 0; i < 80; i++) begin
      front_pix[i] = -1;
      back_pix[i]  = -1;
    end
    front_ok   = 1'b0;
    back_ok    = 1'b0;
    m_uf       = 1'b0;
    m_req      = 1'b0;
    m_req_line = 0;
    pipe.delete();
    // Output value produced by the reset pipeline contents after the first edge.
    pipe.push_back('{rgb: 0, hs: 1, vs: 1});
  endtask

  task automatic model_edge();
    int tmp[80];
    int n, t;
    if (wr_en && (int'(wr_addr) < 80)) back_pix[int'(wr_addr)] = int'(wr_data);
    if (wr_done) back_ok = 1'b1;
    m_req = 1'b0;
    if (int'(x) == 799) begin
      n = (int'(y) + 1) % 525;
      t = (int'(y) + 2) % 525;
      if (n < 480 && !back_ok) m_uf = 1'b1;
      tmp       = front_pix;
      front_pix = back_pix;
      back_pix  = tmp;
      front_ok  = back_ok;
      back_ok   = 1'b0;
      if (t < 480) begin
        m_req      = 1'b1;
        m_req_line = t;
      end
    end
  endtask

  task automatic set_timing(input int xx, input int yy);
    x      = 10'(xx);
    y      = 10'(yy);
    blank  = (xx >= 640) || (yy >= 480);
    hs_in  = !((xx >= int'(HS_START)) && (xx <= int'(HS_END)));
    vs_in  = !((yy >= int'(VS_START)) && (yy <= int'(VS_END)));
  endtask

  task automatic step();
    exp_t e;
    e.hs  = int'(hs_in);
    e.vs  = int'(vs_in);
    e.rgb = (blank || !front_ok) ? 0 : front_pix[int'(x) / 8];
    pipe.push_back(e);
    @(posedge clk);
    #1;
    model_edge();
    check_eq("line_req", int'(line_req), int'(m_req));
    check_eq("req_line", int'(req_line), m_req_line);
    check_eq("underflow", int'(underflow), int'(m_uf));
    if (pipe.size() >= 2) begin
      e = pipe.pop_front();
      if (e.rgb >= 0) check_eq("rgb", int'(rgb), e.rgb);
      check_eq("hs_out", int'(hs_out), e.hs);
      check_eq("vs_out", int'(vs_out), e.vs);
    end
  endtask

  // Modes: 0 random fill+done (with a repeat pulse), 1 fill with index, 2 fill without done,
  // 3 sparse random writes incl. out-of-range, 4 done in the swap cycle, 5 out-of-range write.
  task automatic run_line(input int yy, input int mode, input int xlast);
    int done_x;
    done_x = (mode == 3) ? int'($urandom_range(0, 799)) : int'($urandom_range(80, 790));
    if (mode == 4) done_x = 799;
    if (mode == 5) done_x = 100;
    for (int xx = 0; xx <= xlast; xx++) begin
      set_timing(xx, yy);
      wr_en   = 1'b0;
      wr_addr = 7'd0;
      wr_data = 6'd0;
      wr_done = 1'b0;
      if (mode == 3) begin
        if ($urandom_range(0, 3) == 0) begin
          wr_en   = 1'b1;
          wr_addr = 7'($urandom_range(0, 95));
          wr_data = 6'($urandom);
        end
      end else if (xx < 80) begin
        wr_en   = 1'b1;
        wr_addr = 7'(xx);
        wr_data = (mode == 1 || mode == 5) ? 6'(xx) : 6'($urandom);
      end
      if (mode == 5 && xx == 90) begin
        wr_en   = 1'b1;
        wr_addr = 7'd80;
        wr_data = 6'h3F;
      end
      if (mode != 2 && (xx == done_x || (mode == 0 && xx == done_x + 3))) wr_done = 1'b1;
      step();
    end
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = 7'd0;
    wr_data = 6'd0;
    wr_done = 1'b0;
    set_timing(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rgb", int'(rgb), 0);
    check_eq("rst_hs", int'(hs_out), 1);
    check_eq("rst_vs", int'(vs_out), 1);
    model_reset();
    reset = 1'b0;

    run_line(0, 2, 799);
    run_line(1, 0, 799);
    run_line(5, 0, 300);

    // Asynchronous reset in the middle of a line, held for three cycles.
    reset = 1'b1;
    #1;
    check_eq("rst_mid_rgb", int'(rgb), 0);
    check_eq("rst_mid_hs", int'(hs_out), 1);
    check_eq("rst_mid_vs", int'(vs_out), 1);
    check_eq("rst_mid_req", int'(line_req), 0);
    check_eq("rst_mid_reql", int'(req_line), 0);
    check_eq("rst_mid_uf", int'(underflow), 0);
    for (int i = 0; i < 3; i++) begin
      set_timing(301 + i, 5);
      @(posedge clk);
      #1;
    end
    model_reset();
    reset = 1'b0;

    run_line(0, 1, 799);
    for (int yy = 1; yy <= 3; yy++) run_line(yy, 0, 799);
    run_line(9, 0, 799);
    run_line(10, 1, 799);
    run_line(11, 5, 799);
    run_line(12, 0, 799);
    run_line(13, 3, 799);
    run_line(14, 4, 799);
    run_line(15, 0, 799);
    run_line(476, 0, 799);
    run_line(477, 0, 799);
    run_line(478, 0, 799);
    run_line(479, 2, 799);
    run_line(523, 0, 799);
    run_line(524, 0, 799);
    run_line(0, 0, 799);
    run_line(1, 3, 799);
    run_line(99, 0, 799);
    run_line(100, 0, 799);
    run_line(101, 2, 799);
    run_line(102, 0, 799);
    run_line(103, 0, 799);
    for (int yy = 104; yy < 110; yy++) run_line(yy, int'($urandom_range(0, 5)), 799);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
